expr_string_emitter: RTL and testbench
======================================

// Module: expr_string_emitter
// PURPOSE
//   Transmit side of the digit/operator character-stream check. Takes a
//   packed list of BCD operands and 2-bit operator codes, serialises them as
//   one ASCII byte per accepted transfer, in the form digit (op digit)*.
//   A downstream byte-stream checker sees the complete string as valid
//   (its valid flag high) once the last digit is accepted.
// PARAMETERS
//   MAXN  4  maximum number of operands per string (>=1)
//   CW    3  width of num_cnt; must hold MAXN
// PORTS
//   clk      in   1         rising-edge clock
//   clr      in   1         asynchronous active-high reset
//   start    in   1         request to emit one string; sampled only while busy==0
//   num_cnt  in   CW        number of operands n to emit, valid 1..MAXN
//   digits   in   4*MAXN    operand i at bits [4i+3:4i], BCD 0..9; operand 0 goes first
//   ops      in   2*MAXN    op i at [2i+1:2i] sits between operand i and i+1; 00 '+' 01 '-' 10 '*' 11 '/'
//   ready    in   1         downstream accepts char_out this cycle
//   char_out out  8         ASCII byte being offered
//   char_vld out  1         char_out is valid
//   busy     out  1         string in progress (start ignored)
//   done     out  1         one-cycle pulse after the final byte is accepted
//   err      out  1         one-cycle pulse: start rejected
// BEHAVIOUR
//   - Reset: clr is asynchronous. It forces state IDLE and clears the index,
//     the latched inputs and all outputs (char_out=8'h00, others 0).
//     Reset in mid-string abandons the string. No done or err is produced.
//   - FSM states: IDLE, NUM, OP, FIN. All outputs are registered.
//   - IDLE, start=1 with n in 1..MAXN and every operand 0..n-1 <= 9:
//     latch digits, ops and n; index i=0. Next cycle: NUM, busy=1, char_vld=1,
//     char_out="0"+digits[0].
//   - IDLE, start=1 with n==0, n>MAXN, or any used operand >9: no latch.
//     err=1 for exactly the next cycle. Stay in IDLE. Operands >= n are not checked.
//   - Transfer = posedge with char_vld&&ready. Hold char_out/char_vld stable while ready=0.
//   - NUM, transfer, i<n-1: go to OP and offer the ASCII op for ops[i].
//   - NUM, transfer, i==n-1: go to FIN. char_vld=0, done=1 for that one cycle.
//   - OP, transfer: i<=i+1, go to NUM and offer "0"+digits[i+1].
//   - FIN: go to IDLE next cycle. busy falls with done. A start in FIN is ignored.
//     A new start is sampled from the first IDLE cycle.
//   - Total bytes = 2n-1. With ready held high, n digits take 2n-1 cycles
//     of char_vld, then 1 done cycle.
//   - Latched inputs are frozen while busy. Changes on digits/ops/num_cnt
//     then have no effect.
//   - busy = state!=IDLE. char_vld = state in {NUM,OP}.
// TESTING
//   - n=3, digits={3,2,1}, ops={10,00}, ready=1 -> bytes "1","+","2","*","3"
//     on 5 consecutive cycles. done pulses on cycle 6. A checker fed the
//     bytes ends with valid=1.
//   - Same string, ready low 2 cycles while "+" is offered -> "+" is held
//     3 cycles. The sequence is unchanged and done is delayed by 2.
//   - n=1, digit0=7 -> single byte 8'h37 for one cycle, then done.
//     No operator byte is emitted.
//   - n=0, then n=5 (MAXN=4), then n=2 with digit1=4'hA -> err pulse each time.
//     char_vld and busy stay 0.
//   - start pulsed while busy with different digits -> ignored. The original
//     string completes intact.
//   - clr asserted between clock edges while "*" is offered -> outputs 0 at once.
//     After release, a fresh start emits from operand 0 and there is no stale done.

Source files
------------

// File: rtl/expr_string_emitter.sv
// Serialises a packed list of BCD operands and 2-bit operator codes into an
// ASCII "digit (op digit)*" byte stream over a valid/ready handshake.
module expr_string_emitter #(
    parameter int MAXN = 4,
    parameter int CW   = 3
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [CW-1:0]     num_cnt,
    input  logic [4*MAXN-1:0] digits,
    input  logic [2*MAXN-1:0] ops,
    input  logic              ready,
    output logic [7:0]        char_out,
    output logic              char_vld,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_NUM  = 2'd1;
    localparam logic [1:0] S_OP   = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    logic [1:0]        r_state;
    logic [CW-1:0]     r_idx;
    logic [CW-1:0]     r_n;
    logic [4*MAXN-1:0] r_digits;
    logic [2*MAXN-1:0] r_ops;
    logic [7:0]        r_char;
    logic              r_vld;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic              w_start_ok;
    logic              w_xfer;
    logic              w_last;
    logic [CW-1:0]     w_idx_nxt;
    logic [3:0]        w_dig_nxt;
    logic [1:0]        w_op_cur;

    function automatic logic [7:0] op_ascii(input logic [1:0] code);
        case (code)
            2'b00:   op_ascii = 8'h2B;
            2'b01:   op_ascii = 8'h2D;
            2'b10:   op_ascii = 8'h2A;
            default: op_ascii = 8'h2F;
        endcase
    endfunction

    // Only operands below num_cnt take part in the range check.
    always_comb begin
        w_start_ok = (num_cnt != '0) && (num_cnt <= CW'(MAXN));
        for (int unsigned k = 0; k < MAXN; k++) begin
            if ((CW'(k) < num_cnt) && (digits[4*k +: 4] > 4'd9))
                w_start_ok = 1'b0;
        end
    end

    assign w_idx_nxt = r_idx + CW'(1);
    assign w_last    = (r_idx == r_n - CW'(1));
    assign w_xfer    = r_vld & ready;

    always_comb begin
        w_dig_nxt = '0;
        w_op_cur  = '0;
        for (int unsigned k = 0; k < MAXN; k++) begin
            if (CW'(k) == w_idx_nxt)
                w_dig_nxt = r_digits[4*k +: 4];
            if (CW'(k) == r_idx)
                w_op_cur = r_ops[2*k +: 2];
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_n      <= '0;
            r_digits <= '0;
            r_ops    <= '0;
            r_char   <= '0;
            r_vld    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_start_ok) begin
                            r_digits <= digits;
                            r_ops    <= ops;
                            r_n      <= num_cnt;
                            r_idx    <= '0;
                            r_char   <= {4'h3, digits[3:0]};
                            r_vld    <= 1'b1;
                            r_busy   <= 1'b1;
                            r_state  <= S_NUM;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_NUM: begin
                    if (w_xfer) begin
                        if (w_last) begin
                            r_vld   <= 1'b0;
                            r_char  <= '0;
                            r_done  <= 1'b1;
                            r_state <= S_FIN;
                        end else begin
                            r_char  <= op_ascii(w_op_cur);
                            r_state <= S_OP;
                        end
                    end
                end
                S_OP: begin
                    if (w_xfer) begin
                        r_idx   <= w_idx_nxt;
                        r_char  <= {4'h3, w_dig_nxt};
                        r_state <= S_NUM;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign char_out = r_char;
    assign char_vld = r_vld;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: tb/tb_expr_string_emitter.sv
// Scoreboard bench for expr_string_emitter: drivers queue expected bytes and
// done/err pulses, a negedge monitor pops and compares as the DUT presents them.
module tb_expr_string_emitter;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [2:0]  num_cnt;
    logic [15:0] digits;
    logic [7:0]  ops;
    logic        ready;
    logic [7:0]  char_out;
    logic        char_vld;
    logic        busy;
    logic        done;
    logic        err;

    localparam logic [1:0] K_BYTE = 2'd0;
    localparam logic [1:0] K_DONE = 2'd1;
    localparam logic [1:0] K_ERR  = 2'd2;

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [9:0] q[$];

    expr_string_emitter #(.MAXN(4), .CW(3)) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .num_cnt  (num_cnt),
        .digits   (digits),
        .ops      (ops),
        .ready    (ready),
        .char_out (char_out),
        .char_vld (char_vld),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_pop(input logic [1:0] kind, input logic [7:0] b, input string name);
        logic [9:0] e;
        n_chk++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: got unexpected event %0h expected none", name, {kind, b});
        end else begin
            e = q.pop_front();
            if (e !== {kind, b}) begin
                n_fail++;
                $display("FAIL %s: got %0h expected %0h", name, {kind, b}, e);
            end
        end
    endtask

    // Monitor with a tiny downstream string checker.
    bit         prev_stall = 1'b0;
    logic [7:0] prev_char  = '0;
    bit         ck_want_op = 1'b0;
    bit         ck_valid   = 1'b0;
    bit         ck_bad     = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (clr) begin
                prev_stall = 1'b0;
                ck_want_op = 1'b0;
                ck_valid   = 1'b0;
                ck_bad     = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_char", char_out, prev_char);
                    check("hold_vld", char_vld, 1);
                end
                prev_stall = char_vld && !ready;
                prev_char  = char_out;
                if (char_vld && ready) begin
                    sb_pop(K_BYTE, char_out, "byte");
                    if (!ck_want_op) begin
                        if (!(char_out >= 8'h30 && char_out <= 8'h39)) ck_bad = 1'b1;
                        ck_valid   = 1'b1;
                        ck_want_op = 1'b1;
                    end else begin
                        if (!(char_out inside {8'h2A, 8'h2B, 8'h2D, 8'h2F})) ck_bad = 1'b1;
                        ck_valid   = 1'b0;
                        ck_want_op = 1'b0;
                    end
                end
                if (done) begin
                    sb_pop(K_DONE, 8'h00, "done");
                    check("stream_valid", {30'd0, ck_bad, ck_valid}, 32'd1);
                    ck_want_op = 1'b0;
                    ck_valid   = 1'b0;
                    ck_bad     = 1'b0;
                end
                if (err) sb_pop(K_ERR, 8'h00, "err");
            end
        end
    end

    task automatic run_string(input logic [2:0] n, input logic [15:0] dg, input logic [7:0] op,
                              input string exp, input int stall, input bit inject);
        int cyc;
        for (int i = 0; i < exp.len(); i++) q.push_back({K_BYTE, exp[i]});
        q.push_back({K_DONE, 8'h00});
        num_cnt = n;
        digits  = dg;
        ops     = op;
        ready   = 1'b1;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_on", busy, 1);
        cyc = 0;
        while (!done && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (stall > 0 && cyc == 1) ready = 1'b0;
            if (stall > 0 && cyc == 1 + stall) ready = 1'b1;
            if (inject && cyc == 2) begin
                start   = 1'b1;
                num_cnt = 3'd1;
                digits  = 16'h9999;
                ops     = 8'hFF;
            end
            if (inject && cyc == 3) start = 1'b0;
        end
        check("done_latency", cyc, exp.len() + stall);
        check("busy_in_fin", busy, 1);
        @(posedge clk); #1;
        check("busy_off", busy, 0);
        check("vld_off", char_vld, 0);
    endtask

    task automatic run_err(input logic [2:0] n, input logic [15:0] dg);
        q.push_back({K_ERR, 8'h00});
        num_cnt = n;
        digits  = dg;
        ops     = 8'h00;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("err_pulse", err, 1);
        check("err_busy", busy, 0);
        check("err_vld", char_vld, 0);
        @(posedge clk); #1;
        check("err_single", err, 0);
        check("err_busy2", busy, 0);
    endtask

    initial begin
        int cyc;
        clr     = 1'b1;
        start   = 1'b0;
        ready   = 1'b1;
        num_cnt = '0;
        digits  = '0;
        ops     = '0;
        #12;
        check("reset_outs", {char_out, char_vld, busy, done, err}, 12'h000);
        clr = 1'b0;
        @(posedge clk); #1;

        run_string(3'd3, 16'h0321, 8'h08, "1+2*3", 0, 1'b0);
        run_string(3'd3, 16'h0321, 8'h08, "1+2*3", 2, 1'b0);
        run_string(3'd1, 16'h0007, 8'h00, "7", 0, 1'b0);
        run_string(3'd4, 16'h9058, 8'h2D, "8-5/0*9", 0, 1'b0);
        run_string(3'd2, 16'h0A64, 8'hFF, "4/6", 0, 1'b0);

        run_err(3'd0, 16'h0321);
        run_err(3'd5, 16'h1111);
        run_err(3'd2, 16'h00A3);
        run_err(3'd1, 16'h000F);

        run_string(3'd3, 16'h0321, 8'h08, "1+2*3", 0, 1'b1);

        // Abandon a string mid-flight with an asynchronous clear.
        q.push_back({K_BYTE, 8'h31});
        q.push_back({K_BYTE, 8'h2B});
        q.push_back({K_BYTE, 8'h32});
        num_cnt = 3'd3;
        digits  = 16'h0321;
        ops     = 8'h08;
        ready   = 1'b1;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (cyc < 3) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("star_offered", char_out, 8'h2A);
        #2;
        clr = 1'b1;
        #1;
        check("clr_outs", {char_out, char_vld, busy, done, err}, 12'h000);
        check("clr_sb_drained", q.size(), 0);
        q.delete();
        #3;
        clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("no_stale_done", done, 0);
        run_string(3'd3, 16'h0321, 8'h08, "1+2*3", 0, 1'b0);

        cyc = 0;
        while (q.size() != 0 && cyc < 20) begin
            @(posedge clk);
            cyc++;
        end
        check("sb_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
